// File: rtl/addr_cfg_loader_if.sv
// Byte-stream input, decoder config port and status for the address-table loader.
// The master side is the host link plus the decoder; the slave side is the loader itself.
interface addr_cfg_loader_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       cfg_we;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, cfg_we, cfg_addr, cfg_wdata, busy, done, err, err_code
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, cfg_we, cfg_addr, cfg_wdata, busy, done, err, err_code
    );
endinterface

// File: rtl/addr_cfg_loader.sv
// Frame loader for the Dock address decoder tables: buffers SYNC/START/LEN/data/CHK frames,
// verifies the checksum, then replays the payload as consecutive config writes.
module addr_cfg_loader #(
    parameter int unsigned BUF_DEPTH   = 64,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    addr_cfg_loader_if.slave bus
);
    localparam int unsigned AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [2:0] {StIdle, StAddr, StLen, StData, StChk, StCommit} state_e;

    state_e        state_q;
    logic [7:0]    start_q;
    logic [7:0]    len_q;
    logic [7:0]    idx_q;
    logic [7:0]    sum_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    buf_mem [BUF_DEPTH];
    logic          cfg_we_q;
    logic [7:0]    cfg_addr_q;
    logic [7:0]    cfg_wdata_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic [1:0]    err_code_q;

    logic       rx_ready;
    logic       accept;
    logic       frame_open;
    logic [7:0] sum_next;

    assign rx_ready   = (state_q != StCommit);
    assign accept     = bus.rx_valid & rx_ready;
    assign frame_open = (state_q == StAddr) || (state_q == StLen) ||
                        (state_q == StData) || (state_q == StChk);
    assign sum_next   = sum_q + bus.rx_data;

    assign bus.rx_ready  = rx_ready;
    assign bus.cfg_we    = cfg_we_q;
    assign bus.cfg_addr  = cfg_addr_q;
    assign bus.cfg_wdata = cfg_wdata_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            start_q     <= 8'h00;
            len_q       <= 8'h00;
            idx_q       <= 8'h00;
            sum_q       <= 8'h00;
            tmo_q       <= '0;
            cfg_we_q    <= 1'b0;
            cfg_addr_q  <= 8'h00;
            cfg_wdata_q <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                buf_mem[i] <= 8'h00;
            end
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;

            // An accepted byte always clears the counter, so it wins over an expiring timeout.
            if (frame_open && !accept) begin
                if (tmo_q == TMO_LAST) begin
                    tmo_q      <= '0;
                    state_q    <= StIdle;
                    busy_q     <= 1'b0;
                    err_q      <= 1'b1;
                    err_code_q <= 2'd3;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end else begin
                tmo_q <= '0;
            end

            unique case (state_q)
                StIdle: begin
                    if (accept && bus.rx_data == SYNC) begin
                        state_q <= StAddr;
                        busy_q  <= 1'b1;
                    end
                end
                StAddr: begin
                    if (accept) begin
                        start_q <= bus.rx_data;
                        sum_q   <= bus.rx_data;
                        state_q <= StLen;
                    end
                end
                StLen: begin
                    if (accept) begin
                        len_q <= bus.rx_data;
                        sum_q <= sum_next;
                        idx_q <= 8'h00;
                        if (bus.rx_data == 8'h00 || 32'(bus.rx_data) > BUF_DEPTH) begin
                            state_q    <= StIdle;
                            busy_q     <= 1'b0;
                            err_q      <= 1'b1;
                            err_code_q <= 2'd1;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (accept) begin
                        buf_mem[idx_q[AW-1:0]] <= bus.rx_data;
                        sum_q <= sum_next;
                        idx_q <= idx_q + 8'd1;
                        if (idx_q == len_q - 8'd1) begin
                            state_q <= StChk;
                        end
                    end
                end
                StChk: begin
                    if (accept) begin
                        if (sum_next == 8'h00) begin
                            // First write goes out in the very next cycle.
                            state_q     <= StCommit;
                            cfg_we_q    <= 1'b1;
                            cfg_addr_q  <= start_q;
                            cfg_wdata_q <= buf_mem[0];
                            idx_q       <= 8'd1;
                        end else begin
                            state_q    <= StIdle;
                            busy_q     <= 1'b0;
                            err_q      <= 1'b1;
                            err_code_q <= 2'd2;
                        end
                    end
                end
                StCommit: begin
                    if (idx_q < len_q) begin
                        cfg_addr_q  <= start_q + idx_q;
                        cfg_wdata_q <= buf_mem[idx_q[AW-1:0]];
                        idx_q       <= idx_q + 8'd1;
                    end else begin
                        cfg_we_q <= 1'b0;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
